// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM encoding and default operand width.
package arith_pkg;

  localparam int unsigned SS_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ss_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/response handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = SS_DEFAULT_WIDTH
) ();

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             done_valid;
  logic             done_ready;

  // Requester / result consumer side
  modport master (
    output start_valid, a, b, done_ready,
    input  start_ready, diff, borrow, ovf, done_valid
  );

  // Subtractor side
  modport slave (
    input  start_valid, a, b, done_ready,
    output start_ready, diff, borrow, ovf, done_valid
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - b_in.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  // Difference bit and borrow-out of a single bit position
  always_comb begin
    diff  = a ^ b ^ b_in;
    b_out = (~a & b) | (~(a ^ b) & b_in);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, WIDTH cycles per result behind valid/ready ports.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = SS_DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ss_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic             ovf_q, ovf_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             fs_d;
  logic             fs_bout;

  full_subtractor u_fs (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .b_in (brw_q),
    .diff (fs_d),
    .b_out(fs_bout)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      ovf_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      ovf_q   <= ovf_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
    end
  end

  // Next-state: accept only in IDLE, finish after the last bit, release on done handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_valid)  state_d = RUN;
      RUN:     if (cnt_q == LAST)    state_d = DONE;
      DONE:    if (bus.done_ready)   state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    bus.start_ready = (state_q == IDLE);
    bus.done_valid  = (state_q == DONE);
  end

  // Datapath: load on accept, one subtractor step per RUN cycle, hold otherwise
  always_comb begin
    cnt_d  = cnt_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    res_d  = res_q;
    brw_d  = brw_q;
    ovf_d  = ovf_q;
    amsb_d = amsb_q;
    bmsb_d = bmsb_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          sa_d   = bus.a;
          sb_d   = bus.b;
          brw_d  = 1'b0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          amsb_d = bus.a[WIDTH-1];
          bmsb_d = bus.b[WIDTH-1];
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {fs_d, res_q[WIDTH-1:1]};
        brw_d = fs_bout;
        cnt_d = cnt_q + CW'(1);
        // The final bit produced here is the result MSB, so overflow is decided now
        if (cnt_q == LAST) ovf_d = (amsb_q ^ bmsb_q) & (amsb_q ^ fs_d);
      end
      default: ;
    endcase
  end

  assign bus.diff   = res_q;
  assign bus.borrow = brw_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) with a result scoreboard.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    logic [8:0] r;
    r        = {1'b0, a} - {1'b0, b};
    e.diff   = r[7:0];
    e.borrow = r[8];
    e.ovf    = (a[7] ^ b[7]) & (a[7] ^ r[7]);
    return e;
  endfunction

  // Called at a negedge with the block idle; returns at a negedge after the done handshake.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                       input bit inject, input bit hold_chk, input bit keep_ready,
                       output time t_acc);
    int   lat;
    exp_t e;
    bus.a           = a;
    bus.b           = b;
    bus.start_valid = 1'b1;
    check("start_ready_idle", 32'(bus.start_ready), 32'd1);
    sb_q.push_back(model(a, b));
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.a           = ~a;
    bus.b           = ~b;
    lat = 0;
    while (!bus.done_valid && lat < 40) begin
      if (inject && lat >= 1 && lat <= 5) begin
        bus.start_valid = 1'b1;
        bus.a           = 8'hAA;
      end else begin
        bus.start_valid = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.start_valid = 1'b0;
    if (!bus.done_valid) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_front());
      return;
    end
    check("latency", 32'(lat), 32'd8);
    e = sb_q[0];
    for (int i = 0; i < stall; i++) begin
      bus.done_ready = 1'b0;
      if (hold_chk) begin
        check("hold_diff",   32'(bus.diff),       32'(e.diff));
        check("hold_borrow", 32'(bus.borrow),     32'(e.borrow));
        check("hold_ovf",    32'(bus.ovf),        32'(e.ovf));
        check("hold_valid",  32'(bus.done_valid), 32'd1);
      end
      check("start_ready_busy", 32'(bus.start_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.done_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("diff",       32'(bus.diff),       32'(e.diff));
    check("borrow",     32'(bus.borrow),     32'(e.borrow));
    check("ovf",        32'(bus.ovf),        32'(e.ovf));
    check("done_valid", 32'(bus.done_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_ready) bus.done_ready = 1'b0;
    check("done_valid_after", 32'(bus.done_valid), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t0, t1;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.done_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_done_valid",  32'(bus.done_valid),  32'd0);
    check("rst_diff",        32'(bus.diff),        32'd0);
    check("rst_borrow",      32'(bus.borrow),      32'd0);
    check("rst_ovf",         32'(bus.ovf),         32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases
    do_op(8'h05, 8'h03, 0, 1'b0, 1'b0, 1'b0, t0);
    do_op(8'h03, 8'h05, 0, 1'b0, 1'b0, 1'b0, t0);
    do_op(8'h00, 8'h01, 0, 1'b0, 1'b0, 1'b0, t0);
    do_op(8'h80, 8'h01, 0, 1'b0, 1'b0, 1'b0, t0);
    do_op(8'h7F, 8'hFF, 0, 1'b0, 1'b0, 1'b0, t0);
    do_op(8'hFF, 8'hFF, 0, 1'b0, 1'b0, 1'b0, t0);

    // Backpressure: five stalled cycles in DONE
    do_op(8'h5A, 8'h3C, 5, 1'b0, 1'b1, 1'b0, t0);

    // Request during RUN is ignored
    do_op(8'h12, 8'h34, 0, 1'b1, 1'b0, 1'b0, t0);

    // Back-to-back with done_ready held high
    bus.done_ready = 1'b1;
    do_op(8'h40, 8'h41, 0, 1'b0, 1'b0, 1'b1, t0);
    for (int k = 0; k < 3; k++) begin
      do_op(8'(8'h20 + k), 8'h90, 0, 1'b0, 1'b0, 1'b1, t1);
      check("b2b_period", 32'((t1 - t0) / 10), 32'd10);
      t0 = t1;
    end
    bus.done_ready = 1'b0;

    // Reset mid-RUN at E0+4
    bus.a           = 8'h3C;
    bus.b           = 8'h11;
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_start_ready", 32'(bus.start_ready), 32'd1);
    check("midrst_done_valid",  32'(bus.done_valid),  32'd0);
    check("midrst_diff",        32'(bus.diff),        32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op(8'h10, 8'h10, 0, 1'b0, 1'b0, 1'b0, t0);

    // Random operands with random result stalls
    for (int n = 0; n < 1000; n++) begin
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, t0);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
